btb_assoc: RTL

Set-associative branch target buffer with partial tags, per-set replacement and per-entry control-transfer type; parametrised successor to the direct-lookup BTB in the fetch stage. Looks up the current fetch PC combinationally, together with the gshare direction bit, to produce the next fetch PC. It is trained from ROB commit. Optionally, it contains a speculative return address stack (RAS) with commit-time repair.

---
 rtl/rv32i_types.sv | 55 +++++
 rtl/btb_ras.sv | 83 ++++++++
 rtl/btb_assoc.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I fetch-side types: BTB entry kinds, control-transfer opcodes
// and the commit-time decode that classifies a retired instruction.
package rv32i_types;

  typedef enum logic [1:0] {
    BTB_BR   = 2'd0,
    BTB_JUMP = 2'd1,
    BTB_CALL = 2'd2,
    BTB_RET  = 2'd3
  } btb_type_t;

  localparam logic [6:0] BR_OPCODE   = 7'b1100011;
  localparam logic [6:0] JAL_OPCODE  = 7'b1101111;
  localparam logic [6:0] JALR_OPCODE = 7'b1100111;

  typedef struct packed {
    logic      cft;
    btb_type_t typ;
  } cft_decode_t;

  // x1 (ra) and x5 (t0) are the link registers of the calling convention
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic cft_decode_t decode_cft(input logic [6:0] opcode,
                                             input logic [4:0] rd,
                                             input logic [4:0] rs1);
    cft_decode_t d;
    d.cft = 1'b0;
    d.typ = BTB_BR;
    case (opcode)
      BR_OPCODE: begin
        d.cft = 1'b1;
        d.typ = BTB_BR;
      end
      JAL_OPCODE: begin
        d.cft = 1'b1;
        d.typ = is_link(rd) ? BTB_CALL : BTB_JUMP;
      end
      JALR_OPCODE: begin
        d.cft = 1'b1;
        if (is_link(rs1) && (rd == 5'd0)) d.typ = BTB_RET;
        else if (is_link(rd))             d.typ = BTB_CALL;
        else                              d.typ = BTB_JUMP;
      end
      default: begin
        d.cft = 1'b0;
        d.typ = BTB_BR;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/btb_ras.sv
// Return address stack with a speculative copy driven by fetch and a
// committed copy driven by retirement; flush restores speculative from committed.
module btb_ras #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spec_push,
  input  logic        spec_pop,
  input  logic [31:0] spec_addr,
  input  logic        commit_push,
  input  logic        commit_pop,
  input  logic [31:0] commit_addr,
  input  logic        flush,
  output logic [31:0] top,
  output logic        valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]      s_stack_q [DEPTH];
  logic [PTR_W-1:0] s_ptr_q;
  logic [CNT_W-1:0] s_cnt_q;

  logic [31:0]      c_stack_q [DEPTH];
  logic [PTR_W-1:0] c_ptr_q;
  logic [CNT_W-1:0] c_cnt_q;

  logic [31:0]      c_stack_n [DEPTH];
  logic [PTR_W-1:0] c_ptr_n;
  logic [CNT_W-1:0] c_cnt_n;

  // Committed next state is also the flush image, so a same-cycle commit is included
  always_comb begin
    c_stack_n = c_stack_q;
    c_ptr_n   = c_ptr_q;
    c_cnt_n   = c_cnt_q;
    if (commit_push) begin
      c_stack_n[c_ptr_q] = commit_addr;
      c_ptr_n            = c_ptr_q + 1'b1;
      if (c_cnt_q != FULL) c_cnt_n = c_cnt_q + 1'b1;
    end else if (commit_pop && (c_cnt_q != '0)) begin
      c_ptr_n = c_ptr_q - 1'b1;
      c_cnt_n = c_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_ptr_q <= '0;
      c_cnt_q <= '0;
    end else begin
      c_stack_q <= c_stack_n;
      c_ptr_q   <= c_ptr_n;
      c_cnt_q   <= c_cnt_n;
    end
  end

  // A full push lands on the oldest slot because the buffer is circular
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ptr_q <= '0;
      s_cnt_q <= '0;
    end else if (flush) begin
      s_stack_q <= c_stack_n;
      s_ptr_q   <= c_ptr_n;
      s_cnt_q   <= c_cnt_n;
    end else if (spec_push) begin
      s_stack_q[s_ptr_q] <= spec_addr;
      s_ptr_q            <= s_ptr_q + 1'b1;
      if (s_cnt_q != FULL) s_cnt_q <= s_cnt_q + 1'b1;
    end else if (spec_pop && (s_cnt_q != '0)) begin
      s_ptr_q <= s_ptr_q - 1'b1;
      s_cnt_q <= s_cnt_q - 1'b1;
    end
  end

  assign top   = s_stack_q[s_ptr_q - 1'b1];
  assign valid = (s_cnt_q != '0);

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB with partial tags and round-robin victims, trained at commit.
// Define BTB_RAS_EN to add the speculative return address stack (btb_ras).
module btb_assoc
  import rv32i_types::*;
#(
  parameter int SETS_LOG2 = 4,
  parameter int WAYS      = 2,
  parameter int TAG_W     = 12,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        gshare_take,
  output logic [31:0] fetch_pc_next,
  output logic        fetch_hit,
  output logic [1:0]  fetch_type,
  input  logic        rob_pop,
  input  logic        commit_taken,
  input  logic [6:0]  commit_opcode,
  input  logic [4:0]  commit_rd,
  input  logic [4:0]  commit_rs1,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_pc_next,
  input  logic        flush,
  input  logic        btb_clear
);

  localparam int SETS  = 1 << SETS_LOG2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic              valid_q  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
  logic [31:0]       target_q [SETS][WAYS];
  btb_type_t         type_q   [SETS][WAYS];
  logic [WAY_W-1:0]  victim_q [SETS];

  logic [SETS_LOG2-1:0] f_set;
  logic [TAG_W-1:0]     f_tag;
  logic                 look_hit;
  logic [WAY_W-1:0]     look_way;
  btb_type_t            look_type;
  logic [31:0]          look_target;
  logic [31:0]          pc_plus4;
  logic [31:0]          ras_top;
  logic                 ras_valid;

  assign f_set    = fetch_pc[2 +: SETS_LOG2];
  assign f_tag    = fetch_pc[2 + SETS_LOG2 +: TAG_W];
  assign pc_plus4 = fetch_pc + 32'd4;

  // Scan from the top way down so the lowest matching way is the one kept
  always_comb begin
    look_hit = 1'b0;
    look_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[f_set][w] && (tag_q[f_set][w] == f_tag)) begin
        look_hit = 1'b1;
        look_way = w[WAY_W-1:0];
      end
    end
    look_type   = look_hit ? type_q[f_set][look_way] : BTB_BR;
    look_target = target_q[f_set][look_way];
  end

  always_comb begin
    fetch_pc_next = pc_plus4;
    if (look_hit) begin
      case (look_type)
        BTB_BR:             if (gshare_take) fetch_pc_next = look_target;
        BTB_JUMP, BTB_CALL: fetch_pc_next = look_target;
        BTB_RET:            fetch_pc_next = ras_valid ? ras_top : look_target;
        default:            fetch_pc_next = pc_plus4;
      endcase
    end
  end

  assign fetch_hit  = look_hit;
  assign fetch_type = look_type;

  cft_decode_t          dec;
  logic [SETS_LOG2-1:0] c_set;
  logic [TAG_W-1:0]     c_tag;
  logic                 c_hit;
  logic [WAY_W-1:0]     c_hit_way;
  logic                 c_free;
  logic [WAY_W-1:0]     c_free_way;
  logic [WAY_W-1:0]     wr_way;
  logic                 train_we;

  assign dec   = decode_cft(commit_opcode, commit_rd, commit_rs1);
  assign c_set = commit_pc[2 +: SETS_LOG2];
  assign c_tag = commit_pc[2 + SETS_LOG2 +: TAG_W];

  always_comb begin
    c_hit      = 1'b0;
    c_hit_way  = '0;
    c_free     = 1'b0;
    c_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[c_set][w] && (tag_q[c_set][w] == c_tag)) begin
        c_hit     = 1'b1;
        c_hit_way = w[WAY_W-1:0];
      end
      if (!valid_q[c_set][w]) begin
        c_free     = 1'b1;
        c_free_way = w[WAY_W-1:0];
      end
    end
    if (c_hit)       wr_way = c_hit_way;
    else if (c_free) wr_way = c_free_way;
    else             wr_way = victim_q[c_set];
  end

  assign train_we = rob_pop && dec.cft && commit_taken;

  // Clear shares the reset path so it always beats a same-cycle training write
  always_ff @(posedge clk) begin
    if (!rst_n || btb_clear) begin
      for (int s = 0; s < SETS; s++) begin
        victim_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else if (train_we) begin
      valid_q[c_set][wr_way]  <= 1'b1;
      tag_q[c_set][wr_way]    <= c_tag;
      target_q[c_set][wr_way] <= commit_pc_next;
      type_q[c_set][wr_way]   <= dec.typ;
      if (!c_hit && !c_free)
        victim_q[c_set] <= (int'(victim_q[c_set]) == WAYS - 1) ? '0 : victim_q[c_set] + 1'b1;
    end
  end

`ifdef BTB_RAS_EN
  btb_ras #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .spec_push   (fetch_valid && look_hit && (look_type == BTB_CALL)),
    .spec_pop    (fetch_valid && look_hit && (look_type == BTB_RET)),
    .spec_addr   (pc_plus4),
    .commit_push (rob_pop && dec.cft && (dec.typ == BTB_CALL)),
    .commit_pop  (rob_pop && dec.cft && (dec.typ == BTB_RET)),
    .commit_addr (commit_pc + 32'd4),
    .flush       (flush),
    .top         (ras_top),
    .valid       (ras_valid)
  );
`else
  logic unused_ras;
  assign ras_top    = '0;
  assign ras_valid  = 1'b0;
  assign unused_ras = ^{flush, fetch_valid, commit_pc, RAS_DEPTH == 0};
`endif

endmodule
